// File: rtl/majority_frame_collector.sv
// majority_frame_collector: serial-to-frame collector with ones count and majority flag.
// Define MAJ_OVERRUN_DROP_EN to drop frames on overrun (bit_ready tied 1) and expose overrun_cnt.
module majority_frame_collector #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    input  logic             frame_clear,
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame_data,
    output logic [CNT_W-1:0] frame_ones,
    output logic             frame_major,
    input  logic             frame_ready
`ifdef MAJ_OVERRUN_DROP_EN
    ,
    output logic [7:0]       overrun_cnt
`endif
);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    typedef enum logic {COLLECT, FULL} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_ones, r_pend_ones, r_out_ones, w_word_ones;
    logic [WIDTH-1:0] r_asm, r_out_data, w_word;
    logic             r_out_valid, r_out_major;
    logic             w_accept, w_last, w_drain, w_out_free, w_load_new, w_load_pend;
    assign w_accept    = bit_valid && bit_ready && !frame_clear;
    assign w_last      = w_accept && (r_cnt == LAST);
    assign w_word      = {r_asm[WIDTH-2:0], bit_data};
    assign w_word_ones = r_ones + {{(CNT_W-1){1'b0}}, bit_data};
    assign w_drain     = r_out_valid && frame_ready;
    assign w_out_free  = !r_out_valid || w_drain;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
`ifndef MAJ_OVERRUN_DROP_EN
        if (r_state == COLLECT) w_state_nxt = (w_last && !w_out_free) ? FULL : COLLECT;
        else if (frame_clear || w_drain) w_state_nxt = COLLECT;
`endif
    end
    always_comb begin
`ifdef MAJ_OVERRUN_DROP_EN
        bit_ready = 1'b1;
`else
        bit_ready = (r_state == COLLECT);
`endif
        w_load_new  = w_last && w_out_free;
        w_load_pend = (r_state == FULL) && w_drain && !frame_clear;
    end
    // The assembly register doubles as the pending-frame store while in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_ones      <= '0;
            r_asm       <= '0;
            r_pend_ones <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ones  <= '0;
            r_out_major <= 1'b0;
        end else begin
            if (frame_clear) begin
                r_cnt  <= '0;
                r_ones <= '0;
            end else if (w_accept) begin
                r_asm  <= w_word;
                r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_ones <= w_last ? '0 : w_word_ones;
                if (w_last) r_pend_ones <= w_word_ones;
            end
            if (w_load_new) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_ones  <= w_word_ones;
                r_out_major <= w_word_ones > HALF;
            end else if (w_load_pend) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_asm;
                r_out_ones  <= r_pend_ones;
                r_out_major <= r_pend_ones > HALF;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`ifdef MAJ_OVERRUN_DROP_EN
    logic [7:0] r_overrun;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overrun <= '0;
        else if (w_last && !w_out_free && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
    end
    assign overrun_cnt = r_overrun;
`endif
    assign frame_valid = r_out_valid;
    assign frame_data  = r_out_data;
    assign frame_ones  = r_out_ones;
    assign frame_major = r_out_major;
endmodule

// File: tb/tb_majority_frame_collector.sv
// tb_majority_frame_collector: directed and randomized checks against a frame-level model.
// Build with MAJ_OVERRUN_DROP_EN to exercise the drop variant instead of the stall tests.
module tb_majority_frame_collector;
    logic        clk = 1'b0;
    logic        rst_n, bit_valid, bit_data, frame_clear, frame_ready;
    logic        bit_ready, frame_valid, frame_major;
    logic [15:0] frame_data;
    logic [4:0]  frame_ones;
`ifdef MAJ_OVERRUN_DROP_EN
    logic [7:0]  overrun_cnt;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    majority_frame_collector #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_ready(bit_ready), .frame_clear(frame_clear), .frame_valid(frame_valid),
        .frame_data(frame_data), .frame_ones(frame_ones), .frame_major(frame_major),
        .frame_ready(frame_ready)
`ifdef MAJ_OVERRUN_DROP_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic int ref_ones(input logic [15:0] w);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic logic [22:0] ref_frame(input logic [15:0] w);
        return {1'b1, w, 5'(ref_ones(w)), ref_ones(w) > 8};
    endfunction

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_data  = b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; frame_clear = 1'b0; frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({frame_valid, frame_data, frame_ones, frame_major} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {frame_valid, frame_data, frame_ones, frame_major});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bit_ready: got %b required 1", bit_ready);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] words [8];
        int          ones  [4] = '{9, 8, 16, 0};
        logic        maj   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [22:0] exp;
        words[0] = 16'h917D; words[1] = 16'h5555; words[2] = 16'hFFFF; words[3] = 16'h0000;
        for (int i = 4; i < 8; i++) words[i] = 16'($urandom);
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_word(words[i]);
            exp = (i < 4) ? {1'b1, words[i], 5'(ones[i]), maj[i]} : ref_frame(words[i]);
            n_checks++;
            if ({frame_valid, frame_data, frame_ones, frame_major} !== exp) begin
                n_fail++;
                $display("FAIL pattern_%0d: got v=%b d=%h o=%0d m=%b required %h", i,
                         frame_valid, frame_data, frame_ones, frame_major, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_drain: frame_valid got %b required 0", frame_valid);
        end
    endtask

    task automatic test_clear();
        frame_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bit_valid = 1'b1; bit_data = 1'b1; frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0;
        send_word(16'hF830);
        n_checks++;
        if ({frame_valid, frame_data, frame_ones, frame_major} !== {1'b1, 16'hF830, 5'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_partial: got v=%b d=%h o=%0d m=%b required 1 f830 7 0",
                     frame_valid, frame_data, frame_ones, frame_major);
        end
        @(negedge clk);
    endtask

`ifndef MAJ_OVERRUN_DROP_EN
    task automatic test_backpressure();
        logic [15:0] f1, f2, f3;
        f1 = 16'($urandom); f2 = 16'($urandom); f3 = 16'($urandom);
        frame_ready = 1'b0;
        send_word(f1);
        send_word(f2);
        n_checks++;
        if ({bit_ready, frame_valid, frame_data} !== {1'b0, 1'b1, f1}) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h required 0 1 %h", bit_ready, frame_valid, frame_data, f1);
        end
        bit_valid = 1'b1; bit_data = f3[15];
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bit_ready, frame_data} !== {1'b0, f1}) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b d=%h required 0 %h", bit_ready, frame_data, f1);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        n_checks++;
        if ({bit_ready, frame_valid, frame_data, frame_ones, frame_major} !== {1'b1, ref_frame(f2)}) begin
            n_fail++;
            $display("FAIL bp_pending_move: got rdy=%b v=%b d=%h o=%0d required rdy=1 d=%h",
                     bit_ready, frame_valid, frame_data, frame_ones, f2);
        end
        send_word(f3);
        frame_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({frame_valid, frame_data, frame_ones, frame_major} !== ref_frame(f3)) begin
            n_fail++;
            $display("FAIL bp_frame3: got d=%h o=%0d m=%b required %h", frame_data, frame_ones, frame_major, f3);
        end
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: frame_valid got %b required 0", frame_valid);
        end
    endtask

    task automatic test_full_clear();
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        frame_ready = 1'b0;
        send_word(a);
        send_word(b);
        frame_clear = 1'b1;
        @(negedge clk);
        frame_clear = 1'b0;
        n_checks++;
        if ({bit_ready, frame_valid, frame_data} !== {1'b1, 1'b1, a}) begin
            n_fail++;
            $display("FAIL full_clear: got rdy=%b v=%b d=%h required 1 1 %h", bit_ready, frame_valid, frame_data, a);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clear_discard: frame_valid got %b required 0", frame_valid);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [15:0] w, w2;
        w = 16'($urandom) | 16'h0001; w2 = 16'($urandom);
        frame_ready = 1'b0;
        send_word(w);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({frame_valid, frame_data, frame_ones, frame_major} !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b d=%h o=%0d m=%b required all 0",
                     frame_valid, frame_data, frame_ones, frame_major);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        send_word(w2);
        n_checks++;
        if ({frame_valid, frame_data, frame_ones, frame_major} !== ref_frame(w2)) begin
            n_fail++;
            $display("FAIL async_reset_after: got d=%h o=%0d m=%b required %h", frame_data, frame_ones, frame_major, w2);
        end
        @(negedge clk);
    endtask

`ifndef MAJ_OVERRUN_DROP_EN
    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [15:0] acc = '0;
        logic [15:0] e;
        int          n = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            bit_valid   = $urandom_range(0, 3) != 0;
            bit_data    = 1'($urandom);
            frame_ready = (cyc < 1560) ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (cyc >= 1560) bit_valid = 1'b0;
            if (frame_valid && frame_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got frame %h required none", frame_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({frame_valid, frame_data, frame_ones, frame_major} !== ref_frame(e)) begin
                        n_fail++;
                        $display("FAIL rand_frame: got d=%h o=%0d m=%b required d=%h o=%0d",
                                 frame_data, frame_ones, frame_major, e, ref_ones(e));
                    end
                end
            end
            if (bit_valid && bit_ready) begin
                acc = {acc[14:0], bit_data};
                n++;
                if (n == 16) begin
                    exp_q.push_back(acc);
                    n = 0;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: got %0d frames undelivered required 0", exp_q.size());
        end
    endtask
`else
    task automatic test_overrun();
        logic [15:0] f1;
        f1 = 16'($urandom);
        frame_ready = 1'b0;
        send_word(f1);
        send_word(16'($urandom));
        send_word(16'($urandom));
        n_checks++;
        if ({overrun_cnt, bit_ready, frame_valid, frame_data} !== {8'd2, 1'b1, 1'b1, f1}) begin
            n_fail++;
            $display("FAIL overrun: got cnt=%0d rdy=%b v=%b d=%h required 2 1 1 %h",
                     overrun_cnt, bit_ready, frame_valid, frame_data, f1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_patterns();
        test_clear();
`ifndef MAJ_OVERRUN_DROP_EN
        test_backpressure();
        test_full_clear();
`endif
        test_async_reset();
`ifndef MAJ_OVERRUN_DROP_EN
        test_random();
`else
        test_overrun();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/majority_frame_collector.md
Name: majority_frame_collector

Overview:
- Upstream feeder for the 16-bit majority voter.
- Deserializes a valid/ready serial bit stream into WIDTH-bit frames and keeps a running ones count while bits arrive.
- Presents each completed frame, its ones count and its majority flag on a valid/ready output.
- Two storage stages, an assembly register and an output register, so collection of the next frame overlaps with draining of the current one.

Parameters:
- WIDTH, 16, bits per frame.
- CNT_W, 5, width of the ones count; must hold WIDTH, i.e. clog2(WIDTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_valid  in  1  serial bit is offered.
- bit_data  in  1  serial bit value.
- bit_ready  out  1  collector accepts a bit this cycle.
- frame_clear  in  1  synchronous abort of the partial frame in assembly.
- frame_valid  out  1  output register holds a frame.
- frame_data  out  WIDTH  completed frame; first received bit is in the MSB.
- frame_ones  out  CNT_W  number of 1s in frame_data.
- frame_major  out  1  1 when frame_ones > WIDTH/2 (strict; a tie gives 0).
- frame_ready  in  1  consumer takes the frame.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=COLLECT, bit count=0, assembly ones=0, frame_valid=0, frame_data=0, frame_ones=0, frame_major=0. bit_ready=1 once rst_n deasserts.
- Bit accept: on a rising edge with bit_valid && bit_ready.
  - Shift bit_data into the assembly register LSB side.
  - bit count +1.
  - Assembly ones + bit_data.
- States: COLLECT (bit_ready=1) and FULL (bit_ready=0; a complete frame waits in assembly).
- Frame completion happens on the edge that accepts bit number WIDTH.
  - If the output register is empty, or is being drained this edge (frame_valid && frame_ready), load the output register on that same edge: data, ones = acc + bit, major. frame_valid is high in the next cycle, so latency from last bit to frame_valid is 1 cycle.
  - Otherwise, latch the frame in assembly and go to FULL.
  - Either way, bit count and assembly ones restart from 0.
- FULL leaves only on the edge where the output register drains. The pending frame moves to the output register on that edge, frame_valid stays 1, and the state returns to COLLECT.
- Output handshake:
  - frame_valid && frame_ready with nothing pending: frame_valid falls next cycle.
  - Output fields stay stable while frame_valid=1 and frame_ready=0.
- Count arithmetic is CNT_W bits, unsigned. All-ones WIDTH=16 gives 16 with no wrap.
- frame_clear:
  - Zeroes bit count and assembly ones.
  - In FULL it discards the pending frame and returns to COLLECT.
  - Never touches the output register.
  - Wins over a simultaneous bit accept; that bit is discarded.
- Reset mid-operation discards the partial frame, the pending frame and the output frame immediately.
- frame_major is registered with frame_data, never computed combinationally from outputs.

Optional Feature:
- Macro: MAJ_OVERRUN_DROP_EN.
- Defined:
  - bit_ready is tied 1 and the FULL state does not exist.
  - A frame completing while the output register is full and not draining is dropped.
  - Output port overrun_cnt (8 bits, reset 0) increments, saturating at 255.
- Undefined: stall behaviour as above, and overrun_cnt is absent.

Test Plan:
- Reset, frame_ready=1, stream 1001000101111101 MSB-first -> one cycle after the 16th bit: frame_valid=1, frame_data=16'h917D, frame_ones=9, frame_major=1.
- Stream 0101010101010101 -> frame_ones=8, frame_major=0 (tie); stream 16'hFFFF -> frame_ones=16, frame_major=1; stream 16'h0000 -> ones=0, major=0.
- frame_ready=0, bit_valid held 1 with 48 bits -> frame 1 held in output, frame 2 pending, bit_ready=0 after bit 32. Raise frame_ready for one cycle -> frame 2 moves to output, bit_ready=1 next cycle, frame 3 collected intact.
- Send 7 bits, pulse frame_clear together with bit 8, then send 16 bits of 16'hF830 -> output frame_data=16'hF830, ones=7, major=0; bit 8 is absent.
- Assert rst_n=0 asynchronously mid-frame while frame_valid=1 -> frame_valid=0 and outputs zero without a clock edge; a subsequent full frame is collected correctly.
- With MAJ_OVERRUN_DROP_EN and frame_ready=0, stream 48 bits -> frames 2 and 3 are dropped, overrun_cnt=2, and the output still holds frame 1.
